// File: rtl/sad_search_engine.sv
// sad_search_engine: sliding N-column window SAD with a pipelined adder
// tree and running-minimum tracking for block-matching motion search.
module sad_search_engine #(
    parameter int PIX_W  = 8,
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    localparam int T     = $clog2(N * N),
    localparam int SAD_W = PIX_W + T
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N*N*PIX_W-1:0]     cur_blk,
    input  logic                     can_valid,
    input  logic                     can_sol,
    input  logic                     can_last,
    input  logic [N*PIX_W-1:0]       can_col,
    input  logic [ADDR_W-1:0]        can_addr,
    output logic                     sad_valid,
    output logic [SAD_W-1:0]         sad,
    output logic [ADDR_W-1:0]        sad_addr,
    output logic [SAD_W-1:0]         best_sad,
    output logic [ADDR_W-1:0]        best_addr,
    output logic                     done,
    output logic                     busy
);
    localparam int NN = N * N;
    localparam int FW = $clog2(N + 1);

    logic [PIX_W-1:0]  cur  [NN];
    logic [PIX_W-1:0]  win  [N][N];
    logic [FW-1:0]     fill;
    logic [FW-1:0]     fill_nx;
    logic              ended;
    logic              acc;
    logic [SAD_W-1:0]  tree [T+1][NN];
    logic              tv   [T+2];
    logic              tl   [T+2];
    logic [ADDR_W-1:0] ta   [T+2];

    function automatic logic [SAD_W-1:0] absd(
        input logic [PIX_W-1:0] x,
        input logic [PIX_W-1:0] y
    );
        logic [PIX_W-1:0] d;
        d = (x > y) ? x - y : y - x;
        return SAD_W'(d);
    endfunction

    assign acc       = busy && can_valid && !start && !ended;
    assign sad_valid = tv[T+1];
    assign sad       = tree[T][0];
    assign sad_addr  = ta[T+1];

    // Fill count after an accepted column: restart on row start, else saturate at N.
    always_comb begin
        fill_nx = fill;
        if (can_sol)
            fill_nx = FW'(1);
        else if (fill != FW'(N))
            fill_nx = fill + FW'(1);
    end

    // Search control: block capture, fill tracking, minimum update, done/busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++)
                cur[i] <= '0;
            fill      <= '0;
            ended     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_sad  <= '1;
            best_addr <= '0;
        end else if (start) begin
            for (int i = 0; i < NN; i++)
                cur[i] <= cur_blk[i*PIX_W +: PIX_W];
            fill      <= '0;
            ended     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            best_sad  <= '1;
            best_addr <= '0;
        end else begin
            done <= tl[T+1];
            if (tl[T+1])
                busy <= 1'b0;
            if (acc) begin
                fill <= fill_nx;
                if (can_last)
                    ended <= 1'b1;
            end
            if (tv[T+1] && (tree[T][0] < best_sad)) begin
                best_sad  <= tree[T][0];
                best_addr <= ta[T+1];
            end
        end
    end

    // Candidate window: shift left by one column on every accepted column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++)
                for (int r = 0; r < N; r++)
                    win[c][r] <= '0;
        end else if (acc) begin
            for (int c = 0; c < N - 1; c++)
                for (int r = 0; r < N; r++)
                    win[c][r] <= win[c+1][r];
            for (int r = 0; r < N; r++)
                win[N-1][r] <= can_col[r*PIX_W +: PIX_W];
        end
    end

    // SAD pipeline: token launch, absolute differences, then one tree level per stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < T + 2; s++) begin
                tv[s] <= 1'b0;
                tl[s] <= 1'b0;
                ta[s] <= '0;
            end
            for (int j = 0; j <= T; j++)
                for (int i = 0; i < NN; i++)
                    tree[j][i] <= '0;
        end else begin
            for (int i = 0; i < NN; i++)
                tree[0][i] <= absd(cur[i], win[i % N][i / N]);
            for (int j = 1; j <= T; j++)
                for (int i = 0; i < (NN >> j); i++)
                    tree[j][i] <= tree[j-1][2*i] + tree[j-1][2*i+1];
            if (acc)
                ta[0] <= can_addr;
            for (int s = 1; s < T + 2; s++)
                ta[s] <= ta[s-1];
            if (start) begin
                for (int s = 0; s < T + 2; s++) begin
                    tv[s] <= 1'b0;
                    tl[s] <= 1'b0;
                end
            end else begin
                tv[0] <= acc && (fill_nx == FW'(N));
                tl[0] <= acc && can_last;
                for (int s = 1; s < T + 2; s++) begin
                    tv[s] <= tv[s-1];
                    tl[s] <= tl[s-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_sad_search_engine.sv
// tb_sad_search_engine: self-checking bench for sad_search_engine (N=4,
// 8-bit pixels) using an edge-indexed expectation model plus directed tables.
module tb_sad_search_engine;
    localparam int PIX_W  = 8;
    localparam int N      = 4;
    localparam int ADDR_W = 8;
    localparam int NN     = 16;
    localparam int SAD_W  = 12;
    localparam int LAT    = 5;
    localparam int ONES   = 4095;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [NN*PIX_W-1:0]  cur_blk = '0;
    logic                 can_valid = 1'b0;
    logic                 can_sol = 1'b0;
    logic                 can_last = 1'b0;
    logic [N*PIX_W-1:0]   can_col = '0;
    logic [ADDR_W-1:0]    can_addr = '0;
    logic                 sad_valid;
    logic [SAD_W-1:0]     sad;
    logic [ADDR_W-1:0]    sad_addr;
    logic [SAD_W-1:0]     best_sad;
    logic [ADDR_W-1:0]    best_addr;
    logic                 done;
    logic                 busy;

    sad_search_engine #(.PIX_W(PIX_W), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cur_blk(cur_blk),
        .can_valid(can_valid), .can_sol(can_sol), .can_last(can_last),
        .can_col(can_col), .can_addr(can_addr), .sad_valid(sad_valid),
        .sad(sad), .sad_addr(sad_addr), .best_sad(best_sad),
        .best_addr(best_addr), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // expectations indexed by clock edge number modulo 64
    bit e_sv [64];
    bit e_done [64];
    bit e_bc [64];
    int e_sad [64];
    int e_addr [64];
    int e_best [64];
    int e_baddr [64];

    // reference search state
    bit m_busy = 0;
    bit m_ended = 0;
    int m_fill = 0;
    int m_best = ONES;
    int m_baddr = 0;
    logic [NN*PIX_W-1:0] m_cur = '0;
    logic [N*PIX_W-1:0]  m_win [$];

    // observation statistics
    int sv_cnt = 0;
    int done_cnt = 0;
    int last_sad = -1;
    int last_addr = -1;
    bit seen [256];

    typedef struct {
        logic [7:0] cur_v;
        logic [7:0] can_v;
        int         exp_sad;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int window_sad();
        int s = 0;
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++) begin
                int a = int'(m_cur[(r*N+c)*PIX_W +: PIX_W]);
                int b = int'(m_win[c][r*PIX_W +: PIX_W]);
                s += (a > b) ? a - b : b - a;
            end
        return s;
    endfunction

    task automatic clear_ring();
        for (int i = 0; i < 64; i++) begin
            e_sv[i] = 0; e_done[i] = 0; e_bc[i] = 0;
        end
    endtask

    task automatic check_out();
        int i = cyc % 64;
        if (e_done[i]) m_busy = 0;
        chk("sad_valid", int'(sad_valid), int'(e_sv[i]));
        if (e_sv[i]) begin
            chk("sad", int'(sad), e_sad[i]);
            chk("sad_addr", int'(sad_addr), e_addr[i]);
        end
        if (sad_valid) begin
            sv_cnt++;
            last_sad = int'(sad);
            last_addr = int'(sad_addr);
            seen[sad_addr] = 1;
        end
        chk("done", int'(done), int'(e_done[i]));
        if (done) done_cnt++;
        if (e_bc[i]) begin
            chk("best_sad", int'(best_sad), e_best[i]);
            chk("best_addr", int'(best_addr), e_baddr[i]);
        end
        chk("busy", int'(busy), int'(m_busy));
        e_sv[i] = 0; e_done[i] = 0; e_bc[i] = 0;
    endtask

    task automatic model(input bit st, input logic [NN*PIX_W-1:0] cb,
                         input bit vld, input bit sol, input bit lst,
                         input logic [N*PIX_W-1:0] col, input int ad);
        int n = cyc + 1;
        if (st) begin
            m_busy = 1; m_ended = 0; m_fill = 0; m_cur = cb;
            m_win.delete();
            m_best = ONES; m_baddr = 0;
            for (int d = n; d <= n + LAT + 2; d++) begin
                e_sv[d%64] = 0; e_done[d%64] = 0; e_bc[d%64] = 0;
            end
            e_bc[n%64] = 1; e_best[n%64] = ONES; e_baddr[n%64] = 0;
            return;
        end
        if (m_busy && vld && !m_ended) begin
            int k = (n + LAT + 1) % 64;
            m_win.push_back(col);
            if (m_win.size() > N) void'(m_win.pop_front());
            m_fill = sol ? 1 : (m_fill < N ? m_fill + 1 : N);
            if (m_fill == N) begin
                int s = window_sad();
                int j = (n + LAT) % 64;
                e_sv[j] = 1; e_sad[j] = s; e_addr[j] = ad;
                if (s < m_best) begin m_best = s; m_baddr = ad; end
                e_bc[k] = 1; e_best[k] = m_best; e_baddr[k] = m_baddr;
            end
            if (lst) begin
                m_ended = 1;
                e_done[k] = 1;
                e_bc[k] = 1; e_best[k] = m_best; e_baddr[k] = m_baddr;
            end
        end
    endtask

    task automatic step(input bit st, input logic [NN*PIX_W-1:0] cb,
                        input bit vld, input bit sol, input bit lst,
                        input logic [N*PIX_W-1:0] col, input int ad);
        check_out();
        start = st; cur_blk = cb; can_valid = vld; can_sol = sol;
        can_last = lst; can_col = col; can_addr = ADDR_W'(ad);
        model(st, cb, vld, sol, lst, col, ad);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic go(input logic [NN*PIX_W-1:0] blk);
        step(1, blk, 1, 0, 0, $urandom, 8'hEE);
    endtask

    task automatic colv(input logic [7:0] v, input int ad, input bit sol, input bit lst);
        step(0, '0, 1, sol, lst, {N{v}}, ad);
    endtask

    task automatic clear_stats();
        sv_cnt = 0; done_cnt = 0; last_sad = -1; last_addr = -1;
        for (int i = 0; i < 256; i++) seen[i] = 0;
    endtask

    initial begin
        logic [NN*PIX_W-1:0] rb;
        int ncol;
        int k;

        tbl[0] = '{8'h10, 8'h10, 0};
        tbl[1] = '{8'h00, 8'hFF, 4080};
        tbl[2] = '{8'hFF, 8'h00, 4080};
        tbl[3] = '{8'h80, 8'h7F, 16};
        tbl[4] = '{8'h10, 8'h12, 32};
        clear_ring();

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'($urandom); cur_blk = {4{$urandom}};
            can_valid = 1'($urandom); can_sol = 1'($urandom);
            can_last = 1'($urandom); can_col = $urandom;
            can_addr = ADDR_W'($urandom);
            #1;
            chk("rst_sad_valid", int'(sad_valid), 0);
            chk("rst_sad", int'(sad), 0);
            chk("rst_sad_addr", int'(sad_addr), 0);
            chk("rst_best_sad", int'(best_sad), ONES);
            chk("rst_best_addr", int'(best_addr), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_busy", int'(busy), 0);
        end
        @(negedge clk);
        start = 0; can_valid = 0; can_sol = 0; can_last = 0;
        rst_n = 1'b1;

        // columns without start are ignored
        for (int i = 0; i < 8; i++)
            step(0, '0, 1, 0, i == 7, $urandom, i);

        // basic stream
        clear_stats();
        go({NN{8'h10}});
        for (int a = 0; a < 4; a++) colv(8'h10, a, 0, 0);
        colv(8'h12, 4, 0, 1);
        idle(LAT + 3);
        chk("basic_best_sad", int'(best_sad), 0);
        chk("basic_best_addr", int'(best_addr), 3);
        chk("basic_last_sad", last_sad, 8);
        chk("basic_last_addr", last_addr, 4);
        chk("basic_done_cnt", done_cnt, 1);

        // table of uniform blocks
        foreach (tbl[t]) begin
            clear_stats();
            go({NN{tbl[t].cur_v}});
            for (int a = 0; a < 4; a++) colv(tbl[t].can_v, 8'h40 + a, 0, a == 3);
            idle(LAT + 3);
            chk("tbl_sad", last_sad, tbl[t].exp_sad);
            chk("tbl_best", int'(best_sad), tbl[t].exp_sad);
            chk("tbl_done_cnt", done_cnt, 1);
        end

        // row restart
        clear_stats();
        go({NN{8'h10}});
        for (int a = 1; a <= 9; a++)
            step(0, '0, 1, a == 6, a == 9, $urandom, a);
        idle(LAT + 3);
        chk("restart_gap", int'(seen[6]) + int'(seen[7]) + int'(seen[8]), 0);
        chk("restart_tag", last_addr, 9);
        chk("restart_cnt", sv_cnt, 3);

        // tie followed by a short last
        clear_stats();
        go({NN{8'h10}});
        for (int a = 0; a < 4; a++) colv(8'h11, a, 0, 0);
        for (int a = 4; a < 8; a++) colv(8'h0F, a, a == 4, 0);
        colv(8'h55, 8, 1, 0);
        colv(8'h66, 9, 0, 1);
        idle(LAT + 3);
        chk("tie_best_addr", int'(best_addr), 3);
        chk("tie_best_sad", int'(best_sad), 16);
        chk("tie_sv_cnt", sv_cnt, 2);
        chk("short_done_cnt", done_cnt, 1);

        // abort mid-pipeline
        clear_stats();
        go({NN{8'h20}});
        for (int a = 0; a < 4; a++) colv(8'h21, 8'hA0 + a, 0, 0);
        idle(1);
        go({NN{8'h30}});
        for (int a = 0; a < 4; a++) colv(8'h31, 8'hB0 + a, 0, a == 3);
        idle(LAT + 3);
        chk("abort_stale", int'(seen[8'hA3]), 0);
        chk("abort_done_cnt", done_cnt, 1);
        chk("abort_best_addr", int'(best_addr), 8'hB3);
        chk("abort_best_sad", int'(best_sad), 16);

        // randomized searches
        for (int s = 0; s < 8; s++) begin
            clear_stats();
            for (int i = 0; i < NN; i++) rb[i*PIX_W +: PIX_W] = 8'($urandom);
            go(rb);
            ncol = $urandom_range(4, 14);
            k = 0;
            while (k < ncol) begin
                if ($urandom_range(0, 3) != 0) begin
                    step(0, '0, 1, $urandom_range(0, 6) == 0, k == ncol - 1,
                         $urandom, $urandom_range(0, 255));
                    k++;
                end else begin
                    step(0, '0, 0, 1'($urandom), 0, $urandom, 0);
                end
            end
            step(0, '0, 1, 0, 0, $urandom, 1);
            step(0, '0, 1, 0, 1, $urandom, 2);
            idle(LAT + 3);
            chk("rnd_done_cnt", done_cnt, 1);
        end

        // asynchronous reset mid-search
        go({NN{8'h40}});
        for (int a = 0; a < 5; a++) colv(8'($urandom), a, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_sad_valid", int'(sad_valid), 0);
        chk("arst_best_sad", int'(best_sad), ONES);
        chk("arst_done", int'(done), 0);
        m_busy = 0; m_ended = 0; m_fill = 0;
        m_best = ONES; m_baddr = 0;
        m_win.delete();
        clear_ring();
        can_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        idle(10);
        chk("arst_no_sv", sv_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
